// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg -- shared constants, state encoding and helpers for the
// instruction fetch controller.
//   RstEnable        : active level of rst
//   RomEnable/Disable: romCe levels
//   Valid            : asserted level of instValid
//   Zero             : 32-bit reset/clear value
//   fetch_state_t    : IDLE / REQ / HOLD
// Optional feature macro: FETCH_TIMEOUT_EN (adds WdogLimit for the watchdog).
package fetch_ctrl_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic        RomEnable  = 1'b1;
    localparam logic        RomDisable = 1'b0;
    localparam logic        Valid      = 1'b1;
    localparam logic [31:0] Zero       = 32'h0000_0000;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0]  WdogLimit  = 4'd15;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } fetch_state_t;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_redirect_arb.sv
// fetch_redirect_arb -- combinational target selection for fetch_ctrl.
//   excpt/ejpc : exception redirect request and target (highest priority)
//   jCe/jAddr  : branch/jump redirect request and target
//   pc         : current fetch address
//   redirect   : any redirect requested this cycle
//   target     : selected redirect target, forced word aligned
//   pcNext     : sequential next fetch address (wraps modulo 2^32)
module fetch_redirect_arb
    import fetch_ctrl_pkg::*;
(
    input  logic        excpt,
    input  logic [31:0] ejpc,
    input  logic        jCe,
    input  logic [31:0] jAddr,
    input  logic [31:0] pc,
    output logic        redirect,
    output logic [31:0] target,
    output logic [31:0] pcNext
);

    always_comb begin
        redirect = excpt | jCe;
        target   = excpt ? align_word(ejpc) : align_word(jAddr);
        pcNext   = pc + 32'd4;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch FSM with a single outstanding ROM request.
//   clk, rst           : clock, asynchronous active-high reset
//   stall              : decode cannot accept an instruction this cycle
//   excpt/ejpc         : exception redirect (priority over jCe)
//   jCe/jAddr          : branch/jump redirect
//   romAck/romData     : ROM response for the current romAddr
//   romCe/romAddr      : ROM request and fetch address
//   instValid/inst/instPc : instruction handed to decode, with its address
//   flush              : one-cycle pulse after an accepted redirect
//   fetchTimeout       : one-cycle watchdog pulse
// Optional feature macro: FETCH_TIMEOUT_EN enables the REQ watchdog;
// without it fetchTimeout is tied low and REQ waits indefinitely.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        excpt,
    input  logic [31:0] ejpc,
    input  logic        jCe,
    input  logic [31:0] jAddr,
    input  logic        romAck,
    input  logic [31:0] romData,
    output logic        romCe,
    output logic [31:0] romAddr,
    output logic        instValid,
    output logic [31:0] inst,
    output logic [31:0] instPc,
    output logic        flush,
    output logic        fetchTimeout
);

    fetch_state_t state, state_nxt;

    logic [31:0] addr_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] pc_nxt;
    logic        valid_nxt;
    logic        flush_nxt;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] addr_inc;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0]  wdog, wdog_nxt;
    logic        retry, retry_nxt;
    logic        tmo_nxt;
    logic [3:0]  wdog_inc;

    assign wdog_inc = wdog + 4'd1;
    // The cycle after a timeout romCe is dropped before re-issuing.
    assign romCe = (state == REQ && !retry) ? RomEnable : RomDisable;
`else
    assign romCe        = (state == REQ) ? RomEnable : RomDisable;
    assign fetchTimeout = 1'b0;
`endif

    fetch_redirect_arb u_arb (
        .excpt    (excpt),
        .ejpc     (ejpc),
        .jCe      (jCe),
        .jAddr    (jAddr),
        .pc       (romAddr),
        .redirect (redirect),
        .target   (target),
        .pcNext   (addr_inc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state     <= IDLE;
            romAddr   <= Zero;
            inst      <= Zero;
            instPc    <= Zero;
            instValid <= 1'b0;
            flush     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wdog         <= 4'd0;
            retry        <= 1'b0;
            fetchTimeout <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            romAddr   <= addr_nxt;
            inst      <= inst_nxt;
            instPc    <= pc_nxt;
            instValid <= valid_nxt;
            flush     <= flush_nxt;
`ifdef FETCH_TIMEOUT_EN
            wdog         <= wdog_nxt;
            retry        <= retry_nxt;
            fetchTimeout <= tmo_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = romAddr;
        inst_nxt  = inst;
        pc_nxt    = instPc;
        valid_nxt = instValid;
        flush_nxt = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wdog_nxt  = wdog;
        retry_nxt = 1'b0;
        tmo_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Redirects and acks are ignored until REQ is entered.
                state_nxt = REQ;
                addr_nxt  = Zero;
            end
            REQ: begin
                if (redirect) begin
                    // Redirect wins over stall and discards a same-cycle ack.
                    state_nxt = REQ;
                    addr_nxt  = target;
                    valid_nxt = 1'b0;
                    flush_nxt = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    wdog_nxt  = 4'd0;
`endif
                end else if (romAck && romCe == RomEnable) begin
                    inst_nxt  = romData;
                    pc_nxt    = romAddr;
                    valid_nxt = Valid;
                    addr_nxt  = addr_inc;
                    if (stall)
                        state_nxt = HOLD;
`ifdef FETCH_TIMEOUT_EN
                    wdog_nxt  = 4'd0;
`endif
                end else begin
                    if (instValid && !stall)
                        valid_nxt = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    if (!retry) begin
                        if (wdog_inc == WdogLimit) begin
                            tmo_nxt   = 1'b1;
                            wdog_nxt  = 4'd0;
                            retry_nxt = 1'b1;
                        end else begin
                            wdog_nxt  = wdog_inc;
                        end
                    end
`endif
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_nxt = REQ;
                    addr_nxt  = target;
                    valid_nxt = 1'b0;
                    flush_nxt = 1'b1;
                end else if (!stall) begin
                    state_nxt = REQ;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
